ext_tx_sched: RTL and testbench

EXT_TX_SCHED -- requirements
Module: ext_tx_sched

---
 rtl/ext_tx_sched_pkg.sv | 20 ++
 rtl/ext_tx_rr_arb.sv | 91 +++++++++
 rtl/ext_tx_sched.sv | 155 +++++++++++++++
 tb/tb_ext_tx_sched.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ext_tx_sched_pkg.sv
// Shared types for the external write-command scheduler: default ID pool
// geometry, the arbiter state encoding and a select-width helper.
package ext_tx_sched_pkg;

  localparam int EXT_TID_WIDTH_DEF = 4;
  localparam int NB_TID            = 2 ** EXT_TID_WIDTH_DEF;

  typedef logic [EXT_TID_WIDTH_DEF-1:0] tid_t;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_LOCK = 1'b1
  } arb_state_e;

  // A single source still needs a one-bit select to keep port widths legal.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ext_tx_rr_arb.sv
// Round-robin arbiter with a lock: once a request has been offered downstream
// and refused, the chosen source is held until it is finally accepted.
module ext_tx_rr_arb
  import ext_tx_sched_pkg::*;
#(
  parameter int NB_SRC = 2,
  parameter int SEL_W  = sel_width(NB_SRC)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NB_SRC-1:0] req_i,
  input  logic              gnt_i,
  output logic              req_o,
  output logic [SEL_W-1:0]  sel_o,
  output logic              accept_o,
  output logic [NB_SRC-1:0] gnt_o
);

  arb_state_e       state_q, state_d;
  logic [SEL_W-1:0] rr_q, rr_d;
  logic [SEL_W-1:0] lockSel_q, lockSel_d;
  logic [SEL_W-1:0] rrSel;
  logic [SEL_W-1:0] cand;
  logic             rrFound;

  // Walk the sources starting at the priority pointer; first requester wins.
  always_comb begin
    rrSel   = rr_q;
    rrFound = 1'b0;
    cand    = '0;
    for (int i = 0; i < NB_SRC; i++) begin
      cand = SEL_W'((int'(rr_q) + i) % NB_SRC);
      if (!rrFound && req_i[cand]) begin
        rrSel   = cand;
        rrFound = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    lockSel_d = lockSel_q;
    req_o     = 1'b0;
    sel_o     = rrSel;
    unique case (state_q)
      ARB_IDLE: begin
        req_o = |req_i;
        sel_o = rrSel;
        if (req_o && !gnt_i) begin
          state_d   = ARB_LOCK;
          lockSel_d = rrSel;
        end
      end
      ARB_LOCK: begin
        // A source that withdraws its request releases the lock.
        sel_o = lockSel_q;
        req_o = req_i[lockSel_q];
        if (gnt_i || !req_o) begin
          state_d = ARB_IDLE;
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase

    accept_o = req_o & gnt_i;
    gnt_o    = '0;
    if (accept_o) begin
      gnt_o[sel_o] = 1'b1;
    end

    rr_d = rr_q;
    if (accept_o) begin
      rr_d = (int'(sel_o) == NB_SRC - 1) ? '0 : sel_o + SEL_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ARB_IDLE;
      rr_q      <= '0;
      lockSel_q <= '0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      lockSel_q <= lockSel_d;
    end
  end

endmodule

// File: rtl/ext_tx_sched.sv
// Shares one external write-command port between NB_SRC sources: arbitrates,
// allocates transaction IDs from a pool and tracks completions per source.
module ext_tx_sched
  import ext_tx_sched_pkg::*;
#(
  parameter int NB_SRC          = 2,
  parameter int EXT_ADD_WIDTH   = 29,
  parameter int EXT_OPC_WIDTH   = 12,
  parameter int EXT_TID_WIDTH   = 4,
  parameter int MCHAN_LEN_WIDTH = 15
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [NB_SRC*EXT_ADD_WIDTH-1:0]   src_cmd_add_i,
  input  logic [NB_SRC*EXT_OPC_WIDTH-1:0]   src_cmd_opc_i,
  input  logic [NB_SRC*MCHAN_LEN_WIDTH-1:0] src_cmd_len_i,
  input  logic [NB_SRC-1:0]                 src_cmd_bst_i,
  input  logic [NB_SRC-1:0]                 src_cmd_req_i,
  output logic [NB_SRC-1:0]                 src_cmd_gnt_o,
  output logic [EXT_ADD_WIDTH-1:0]          cmd_add_o,
  output logic [EXT_OPC_WIDTH-1:0]          cmd_opc_o,
  output logic [MCHAN_LEN_WIDTH-1:0]        cmd_len_o,
  output logic                              cmd_bst_o,
  output logic [EXT_TID_WIDTH-1:0]          cmd_tid_o,
  output logic                              cmd_req_o,
  input  logic                              cmd_gnt_i,
  output logic                              valid_tid_o,
  input  logic                              release_tid_i,
  input  logic [EXT_TID_WIDTH-1:0]          res_tid_i,
  output logic [NB_SRC-1:0]                 src_done_o,
  output logic [NB_SRC-1:0]                 src_busy_o,
  output logic                              err_o
);

  localparam int NB_TID_P = 2 ** EXT_TID_WIDTH;
  localparam int SEL_W    = sel_width(NB_SRC);
  localparam int CNT_W    = EXT_TID_WIDTH + 1;

  logic [NB_TID_P-1:0]      freeVec_q, freeVec_d;
  logic [SEL_W-1:0]         ownerTab_q [NB_TID_P];
  logic [CNT_W-1:0]         outCnt_q [NB_SRC];
  logic [CNT_W-1:0]         outCnt_d [NB_SRC];
  logic [NB_SRC-1:0]        done_q, done_d;
  logic                     err_q, err_d;
  logic [SEL_W-1:0]         sel;
  logic                     accept;
  logic                     relValid;
  logic                     relBogus;
  logic [SEL_W-1:0]         relOwner;
  logic [EXT_TID_WIDTH-1:0] allocTid;

  ext_tx_rr_arb #(
    .NB_SRC (NB_SRC),
    .SEL_W  (SEL_W)
  ) u_arb (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .req_i    (src_cmd_req_i),
    .gnt_i    (cmd_gnt_i & valid_tid_o),
    .req_o    (cmd_req_o),
    .sel_o    (sel),
    .accept_o (accept),
    .gnt_o    (src_cmd_gnt_o)
  );

  assign cmd_add_o = src_cmd_add_i[int'(sel)*EXT_ADD_WIDTH +: EXT_ADD_WIDTH];
  assign cmd_opc_o = src_cmd_opc_i[int'(sel)*EXT_OPC_WIDTH +: EXT_OPC_WIDTH];
  assign cmd_len_o = src_cmd_len_i[int'(sel)*MCHAN_LEN_WIDTH +: MCHAN_LEN_WIDTH];
  assign cmd_bst_o = src_cmd_bst_i[sel];

  // Lowest-index free ID, taken from the registered pool only so that an ID
  // released this cycle cannot be handed out again before it is actually free.
  always_comb begin
    allocTid = '0;
    for (int t = NB_TID_P - 1; t >= 0; t--) begin
      if (freeVec_q[t]) begin
        allocTid = EXT_TID_WIDTH'(t);
      end
    end
  end

  assign valid_tid_o = |freeVec_q;
  assign cmd_tid_o   = allocTid;

  assign relOwner = ownerTab_q[res_tid_i];
  assign relValid = release_tid_i & ~freeVec_q[res_tid_i];
  assign relBogus = release_tid_i &  freeVec_q[res_tid_i];

  // Accept and release never touch the same ID: accept takes a free one,
  // a valid release only ever targets a busy one.
  always_comb begin
    freeVec_d = freeVec_q;
    if (relValid) begin
      freeVec_d[res_tid_i] = 1'b1;
    end
    if (accept) begin
      freeVec_d[allocTid] = 1'b0;
    end

    done_d = '0;
    if (relValid) begin
      done_d[relOwner] = 1'b1;
    end

    err_d = err_q | relBogus;

    for (int i = 0; i < NB_SRC; i++) begin
      outCnt_d[i] = outCnt_q[i];
      if (src_cmd_gnt_o[i] && !done_d[i]) begin
        outCnt_d[i] = outCnt_q[i] + CNT_W'(1);
      end else if (!src_cmd_gnt_o[i] && done_d[i]) begin
        outCnt_d[i] = outCnt_q[i] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      freeVec_q <= '1;
      done_q    <= '0;
      err_q     <= 1'b0;
      for (int i = 0; i < NB_SRC; i++) begin
        outCnt_q[i] <= '0;
      end
    end else begin
      freeVec_q <= freeVec_d;
      done_q    <= done_d;
      err_q     <= err_d;
      for (int i = 0; i < NB_SRC; i++) begin
        outCnt_q[i] <= outCnt_d[i];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int t = 0; t < NB_TID_P; t++) begin
        ownerTab_q[t] <= '0;
      end
    end else if (accept) begin
      ownerTab_q[allocTid] <= sel;
    end
  end

  always_comb begin
    src_busy_o = '0;
    for (int i = 0; i < NB_SRC; i++) begin
      src_busy_o[i] = |outCnt_q[i];
    end
  end

  assign src_done_o = done_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_ext_tx_sched.sv
// Self-checking bench for ext_tx_sched: a directed vector table, directed
// pool-exhaustion and reset sequences, then random traffic against a model.
module tb_ext_tx_sched;
  import ext_tx_sched_pkg::*;

  localparam int NSRC = 2;
  localparam int AW   = 29;
  localparam int OW   = 12;
  localparam int TW   = 4;
  localparam int LW   = 15;

  logic            clk = 1'b0;
  logic            rst;
  logic [NSRC*AW-1:0] srcAdd;
  logic [NSRC*OW-1:0] srcOpc;
  logic [NSRC*LW-1:0] srcLen;
  logic [NSRC-1:0] srcBst;
  logic [NSRC-1:0] srcReq;
  logic [NSRC-1:0] srcGnt;
  logic [AW-1:0]   cmdAdd;
  logic [OW-1:0]   cmdOpc;
  logic [LW-1:0]   cmdLen;
  logic            cmdBst;
  tid_t            cmdTid;
  logic            cmdReq;
  logic            cmdGnt;
  logic            validTid;
  logic            relTid;
  tid_t            resTid;
  logic [NSRC-1:0] srcDone;
  logic [NSRC-1:0] srcBusy;
  logic            err;

  logic [AW-1:0]   addrOf [NSRC];
  logic [OW-1:0]   opcOf  [NSRC];

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  ext_tx_sched #(
    .NB_SRC          (NSRC),
    .EXT_ADD_WIDTH   (AW),
    .EXT_OPC_WIDTH   (OW),
    .EXT_TID_WIDTH   (TW),
    .MCHAN_LEN_WIDTH (LW)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .src_cmd_add_i (srcAdd),
    .src_cmd_opc_i (srcOpc),
    .src_cmd_len_i (srcLen),
    .src_cmd_bst_i (srcBst),
    .src_cmd_req_i (srcReq),
    .src_cmd_gnt_o (srcGnt),
    .cmd_add_o     (cmdAdd),
    .cmd_opc_o     (cmdOpc),
    .cmd_len_o     (cmdLen),
    .cmd_bst_o     (cmdBst),
    .cmd_tid_o     (cmdTid),
    .cmd_req_o     (cmdReq),
    .cmd_gnt_i     (cmdGnt),
    .valid_tid_o   (validTid),
    .release_tid_i (relTid),
    .res_tid_i     (resTid),
    .src_done_o    (srcDone),
    .src_busy_o    (srcBusy),
    .err_o         (err)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic applyStimulus(input logic [NSRC-1:0] req, input logic gnt, input logic rel, input tid_t res);
    srcReq = req;
    cmdGnt = gnt;
    relTid = rel;
    resTid = res;
  endtask

  task automatic setFields(input int s, input logic [AW-1:0] a, input logic [OW-1:0] o,
                           input logic [LW-1:0] l, input logic b);
    srcAdd[s*AW +: AW] = a;
    srcOpc[s*OW +: OW] = o;
    srcLen[s*LW +: LW] = l;
    srcBst[s]          = b;
    addrOf[s]          = a;
    opcOf[s]           = o;
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus('0, 1'b0, 1'b0, '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [1:0] req;
    logic       gnt;
    logic       rel;
    tid_t       res;
    logic       expReq;
    logic [1:0] expGnt;
    int         expSel;
    tid_t       expTid;
    logic       expValid;
    logic [1:0] expBusy;
    logic [1:0] expDone;
    logic       expErr;
  } vec_t;

  vec_t vecs [18];

  function automatic vec_t mkVec(input logic [1:0] req, input logic gnt, input logic rel, input int res,
                                 input logic eReq, input logic [1:0] eGnt, input int eSel, input int eTid,
                                 input logic eValid, input logic [1:0] eBusy, input logic [1:0] eDone,
                                 input logic eErr);
    vec_t v;
    v.req = req; v.gnt = gnt; v.rel = rel; v.res = tid_t'(res);
    v.expReq = eReq; v.expGnt = eGnt; v.expSel = eSel; v.expTid = tid_t'(eTid);
    v.expValid = eValid; v.expBusy = eBusy; v.expDone = eDone; v.expErr = eErr;
    return v;
  endfunction

  // ---------------- behavioural reference model ----------------
  bit         mBusy  [NB_TID];
  int         mOwner [NB_TID];
  int         mOut   [NSRC];
  int         mRr;
  bit         mLocked;
  int         mLockSrc;
  bit         mErr;
  logic [1:0] mDone;

  task automatic modelReset();
    for (int t = 0; t < NB_TID; t++) begin
      mBusy[t]  = 1'b0;
      mOwner[t] = 0;
    end
    for (int s = 0; s < NSRC; s++) mOut[s] = 0;
    mRr = 0; mLocked = 1'b0; mLockSrc = 0; mErr = 1'b0; mDone = '0;
  endtask

  function automatic void modelView(input logic [1:0] req, input logic gnt, output logic eReq,
                                    output int eSel, output int eTid, output logic eValid,
                                    output logic eAccept);
    bit found;
    eValid = 1'b0;
    eTid   = 0;
    for (int t = NB_TID - 1; t >= 0; t--) begin
      if (!mBusy[t]) begin
        eValid = 1'b1;
        eTid   = t;
      end
    end
    eSel  = 0;
    found = 1'b0;
    if (mLocked) begin
      eSel = mLockSrc;
      eReq = req[mLockSrc];
    end else begin
      eReq = |req;
      for (int k = 0; k < NSRC; k++) begin
        if (!found && req[(mRr + k) % NSRC]) begin
          eSel  = (mRr + k) % NSRC;
          found = 1'b1;
        end
      end
    end
    eAccept = eReq && gnt && eValid;
  endfunction

  task automatic modelStep(input logic [1:0] req, input logic gnt, input logic rel, input tid_t res);
    logic eReq, eValid, eAccept;
    int   eSel, eTid;
    modelView(req, gnt, eReq, eSel, eTid, eValid, eAccept);
    mDone = '0;
    if (rel) begin
      if (mBusy[res]) begin
        mBusy[res] = 1'b0;
        mOut[mOwner[res]]--;
        mDone[mOwner[res]] = 1'b1;
      end else begin
        mErr = 1'b1;
      end
    end
    if (eAccept) begin
      mBusy[eTid]  = 1'b1;
      mOwner[eTid] = eSel;
      mOut[eSel]++;
      mRr     = (eSel + 1) % NSRC;
      mLocked = 1'b0;
    end else if (eReq) begin
      mLocked  = 1'b1;
      mLockSrc = eSel;
    end else begin
      mLocked = 1'b0;
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [1:0] rq;
    logic       g, rl, eReq, eValid, eAccept;
    tid_t       rs;
    int         eSel, eTid, pick;
    logic [1:0] eBusy;

    srcAdd = '0; srcOpc = '0; srcLen = '0; srcBst = '0;
    setFields(0, 29'h0000_1000, 12'h0A1, 15'd16, 1'b1);
    setFields(1, 29'h0000_2000, 12'h0B2, 15'd32, 1'b0);
    doReset();

    // Alternating grants, done pulses, lock against a higher-priority source,
    // and a bogus release.
    vecs[0]  = mkVec(2'b00, 0, 0, 0, 0, 2'b00, -1, 0, 1, 2'b00, 2'b00, 0);
    vecs[1]  = mkVec(2'b11, 1, 0, 0, 1, 2'b01,  0, 0, 1, 2'b00, 2'b00, 0);
    vecs[2]  = mkVec(2'b11, 1, 0, 0, 1, 2'b10,  1, 1, 1, 2'b01, 2'b00, 0);
    vecs[3]  = mkVec(2'b11, 1, 0, 0, 1, 2'b01,  0, 2, 1, 2'b11, 2'b00, 0);
    vecs[4]  = mkVec(2'b01, 1, 0, 0, 1, 2'b01,  0, 3, 1, 2'b11, 2'b00, 0);
    vecs[5]  = mkVec(2'b00, 0, 1, 3, 0, 2'b00, -1, 4, 1, 2'b11, 2'b00, 0);
    vecs[6]  = mkVec(2'b00, 0, 1, 0, 0, 2'b00, -1, 3, 1, 2'b11, 2'b01, 0);
    vecs[7]  = mkVec(2'b00, 0, 1, 2, 0, 2'b00, -1, 0, 1, 2'b11, 2'b01, 0);
    vecs[8]  = mkVec(2'b00, 0, 1, 1, 0, 2'b00, -1, 0, 1, 2'b10, 2'b01, 0);
    vecs[9]  = mkVec(2'b00, 0, 0, 0, 0, 2'b00, -1, 0, 1, 2'b00, 2'b10, 0);
    vecs[10] = mkVec(2'b10, 1, 0, 0, 1, 2'b10,  1, 0, 1, 2'b00, 2'b00, 0);
    vecs[11] = mkVec(2'b10, 0, 0, 0, 1, 2'b00,  1, 1, 1, 2'b10, 2'b00, 0);
    vecs[12] = mkVec(2'b10, 0, 0, 0, 1, 2'b00,  1, 1, 1, 2'b10, 2'b00, 0);
    vecs[13] = mkVec(2'b11, 0, 0, 0, 1, 2'b00,  1, 1, 1, 2'b10, 2'b00, 0);
    vecs[14] = mkVec(2'b11, 1, 0, 0, 1, 2'b10,  1, 1, 1, 2'b10, 2'b00, 0);
    vecs[15] = mkVec(2'b01, 1, 0, 0, 1, 2'b01,  0, 2, 1, 2'b10, 2'b00, 0);
    vecs[16] = mkVec(2'b00, 0, 1, 7, 0, 2'b00, -1, 3, 1, 2'b11, 2'b00, 0);
    vecs[17] = mkVec(2'b00, 0, 0, 0, 0, 2'b00, -1, 3, 1, 2'b11, 2'b00, 1);

    for (int v = 0; v < 18; v++) begin
      applyStimulus(vecs[v].req, vecs[v].gnt, vecs[v].rel, vecs[v].res);
      @(negedge clk);
      checkOutput($sformatf("vec%0d cmd_req", v), 32'(cmdReq), 32'(vecs[v].expReq));
      checkOutput($sformatf("vec%0d src_gnt", v), 32'(srcGnt), 32'(vecs[v].expGnt));
      checkOutput($sformatf("vec%0d tid", v), 32'(cmdTid), 32'(vecs[v].expTid));
      checkOutput($sformatf("vec%0d valid_tid", v), 32'(validTid), 32'(vecs[v].expValid));
      checkOutput($sformatf("vec%0d busy", v), 32'(srcBusy), 32'(vecs[v].expBusy));
      checkOutput($sformatf("vec%0d done", v), 32'(srcDone), 32'(vecs[v].expDone));
      checkOutput($sformatf("vec%0d err", v), 32'(err), 32'(vecs[v].expErr));
      if (vecs[v].expSel >= 0)
        checkOutput($sformatf("vec%0d cmd_add", v), 32'(cmdAdd), 32'(addrOf[vecs[v].expSel]));
      @(posedge clk);
      #1;
    end

    // Pool exhaustion, then a single release frees exactly that ID.
    doReset();
    for (int i = 0; i < NB_TID; i++) begin
      applyStimulus(2'b01, 1'b1, 1'b0, '0);
      @(negedge clk);
      checkOutput($sformatf("fill%0d gnt", i), 32'(srcGnt), 32'h1);
      checkOutput($sformatf("fill%0d tid", i), 32'(cmdTid), 32'(i));
      @(posedge clk);
      #1;
    end
    applyStimulus(2'b01, 1'b1, 1'b0, '0);
    @(negedge clk);
    checkOutput("full valid_tid", 32'(validTid), 32'h0);
    checkOutput("full cmd_req", 32'(cmdReq), 32'h1);
    checkOutput("full gnt", 32'(srcGnt), 32'h0);
    @(posedge clk);
    #1;
    applyStimulus(2'b01, 1'b1, 1'b1, tid_t'(5));
    @(negedge clk);
    checkOutput("release5 valid_tid", 32'(validTid), 32'h0);
    checkOutput("release5 gnt", 32'(srcGnt), 32'h0);
    @(posedge clk);
    #1;
    applyStimulus(2'b01, 1'b1, 1'b0, '0);
    @(negedge clk);
    checkOutput("after5 valid_tid", 32'(validTid), 32'h1);
    checkOutput("after5 tid", 32'(cmdTid), 32'h5);
    checkOutput("after5 gnt", 32'(srcGnt), 32'h1);
    checkOutput("after5 done", 32'(srcDone), 32'h1);
    @(posedge clk);
    #1;

    // Reset with outstanding writes discards them; a late release is an error.
    doReset();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(2'b11, 1'b1, 1'b0, '0);
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    applyStimulus(2'b00, 1'b0, 1'b0, '0);
    @(negedge clk);
    checkOutput("prereset busy", 32'(srcBusy), 32'h3);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("postreset busy", 32'(srcBusy), 32'h0);
    checkOutput("postreset valid_tid", 32'(validTid), 32'h1);
    checkOutput("postreset tid", 32'(cmdTid), 32'h0);
    checkOutput("postreset err", 32'(err), 32'h0);
    @(posedge clk);
    #1;
    applyStimulus(2'b00, 1'b0, 1'b1, tid_t'(2));
    @(posedge clk);
    #1;
    applyStimulus(2'b00, 1'b0, 1'b0, '0);
    @(negedge clk);
    checkOutput("late release err", 32'(err), 32'h1);
    checkOutput("late release done", 32'(srcDone), 32'h0);
    @(posedge clk);
    #1;

    // Random traffic; sources hold a request (with stable fields) until granted.
    doReset();
    modelReset();
    rq = '0;
    for (int n = 0; n < 2000; n++) begin
      for (int s = 0; s < NSRC; s++) begin
        if (!rq[s] && $urandom_range(2) == 0) begin
          rq[s] = 1'b1;
          setFields(s, AW'($urandom), OW'($urandom), LW'($urandom), 1'($urandom));
        end
      end
      g  = ($urandom_range(3) != 0);
      rl = 1'b0;
      rs = '0;
      if ($urandom_range(2) == 0) begin
        pick = $urandom_range(NB_TID - 1);
        if ($urandom_range(29) == 0) begin
          rl = 1'b1;
          rs = tid_t'(pick);
        end else begin
          for (int k = 0; k < NB_TID; k++) begin
            if (!rl && mBusy[(pick + k) % NB_TID]) begin
              rl = 1'b1;
              rs = tid_t'((pick + k) % NB_TID);
            end
          end
        end
      end
      applyStimulus(rq, g, rl, rs);
      @(negedge clk);
      modelView(rq, g, eReq, eSel, eTid, eValid, eAccept);
      for (int s = 0; s < NSRC; s++) eBusy[s] = (mOut[s] != 0);
      checkOutput("rnd cmd_req", 32'(cmdReq), 32'(eReq));
      checkOutput("rnd gnt", 32'(srcGnt), eAccept ? (32'h1 << eSel) : 32'h0);
      checkOutput("rnd valid_tid", 32'(validTid), 32'(eValid));
      if (eValid) checkOutput("rnd tid", 32'(cmdTid), 32'(eTid));
      checkOutput("rnd busy", 32'(srcBusy), 32'(eBusy));
      checkOutput("rnd done", 32'(srcDone), 32'(mDone));
      checkOutput("rnd err", 32'(err), 32'(mErr));
      if (eReq) begin
        checkOutput("rnd cmd_add", 32'(cmdAdd), 32'(addrOf[eSel]));
        checkOutput("rnd cmd_opc", 32'(cmdOpc), 32'(opcOf[eSel]));
      end
      @(posedge clk);
      modelStep(rq, g, rl, rs);
      #1;
      if (eAccept) rq[eSel] = 1'b0;
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
